operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/rv_pkg.sv | 27 ++
 rtl/rv_src_decode.sv | 47 ++++
 rtl/operand_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I operand-fetch definitions.
//   - Default datapath width and architectural register count.
//   - Major opcode constants used by the source/destination decoder.
//   - src_dec_t: which register fields an instruction actually uses.
package rv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic [4:0] rd;
  } src_dec_t;

endpackage

// File: rtl/rv_src_decode.sv
// Combinational source/destination usage decoder.
// Ports:
//   opcode_i     [6:0]  instruction opcode field
//   rd_i         [4:0]  instruction rd field
//   uses_rs1_o          instruction reads rs1
//   uses_rs2_o          instruction reads rs2
//   writes_rd_o         instruction format writes rd (before the x0 check)
//   rd_o         [4:0]  destination index (rd field passed through)
module rv_src_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       writes_rd_o,
  output logic [4:0] rd_o
);

  always_comb begin
    uses_rs1_o  = 1'b0;
    uses_rs2_o  = 1'b0;
    writes_rd_o = 1'b0;
    case (opcode_i)
      OP_REG: begin
        uses_rs1_o  = 1'b1;
        uses_rs2_o  = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1_o  = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        writes_rd_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_o = rd_i;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses the retiring
// writeback, tracks in-flight destinations in a busy scoreboard and stalls
// on RAW/WAW hazards, then registers the instruction for execute.
// Ports:
//   clk, rst (synchronous, active-low)
//   in_valid/in_ready, in_pc, in_instr      upstream instruction handshake
//   rs1_addr, rs2_addr / rs1_data, rs2_data  reg_file read port
//   wb_valid, wb_rd, wb_data                 retiring writeback
//   flush                                    drop the held output entry
//   out_valid/out_ready, out_pc, out_instr,
//   out_op_a, out_op_b, out_rd, out_rd_wr    registered output to execute
module operand_fetch
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_rd,
  output logic            out_rd_wr
);

  src_dec_t dec;

  rv_src_decode u_dec (
    .opcode_i   (in_instr[6:0]),
    .rd_i       (in_instr[11:7]),
    .uses_rs1_o (dec.uses_rs1),
    .uses_rs2_o (dec.uses_rs2),
    .writes_rd_o(dec.writes_rd),
    .rd_o       (dec.rd)
  );

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_rd_wr_q;
  logic [31:0]     out_pc_q, out_instr_q;
  logic [XLEN-1:0] out_op_a_q, out_op_b_q;
  logic [4:0]      out_rd_q;

  // Writes to x0 are architecturally invisible, so they never mark busy.
  logic rd_wr;
  assign rd_wr = dec.writes_rd && (dec.rd != 5'd0);

  // A writeback retiring this cycle resolves the hazard on its register,
  // because its data is forwarded straight into the operand mux.
  logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  assign wb_hit_rs1 = wb_valid && (wb_rd == rs1_addr);
  assign wb_hit_rs2 = wb_valid && (wb_rd == rs2_addr);
  assign wb_hit_rd  = wb_valid && (wb_rd == dec.rd);

  logic pend_rs1, pend_rs2, waw, stall, accept;
  assign pend_rs1 = dec.uses_rs1 && busy_q[rs1_addr] && !wb_hit_rs1;
  assign pend_rs2 = dec.uses_rs2 && busy_q[rs2_addr] && !wb_hit_rs2;
  assign waw      = rd_wr && busy_q[dec.rd] && !wb_hit_rd;
  assign stall    = in_valid && (pend_rs1 || pend_rs2 || waw);

  // Flush blocks accept so a dropped entry cannot be replaced in that cycle.
  assign in_ready = rst && !flush && !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  logic [XLEN-1:0] op_a, op_b;
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (dec.uses_rs1 && rs1_addr != 5'd0) op_a = wb_hit_rs1 ? wb_data : rs1_data;
    if (dec.uses_rs2 && rs2_addr != 5'd0) op_b = wb_hit_rs2 ? wb_data : rs2_data;
  end

  // Per-register scoreboard update. Set (new in-flight writer) beats clear
  // (writeback or flushed entry) when both hit the same index.
  logic flush_clr;
  assign flush_clr = flush && out_valid_q && out_rd_wr_q;

  assign busy_d[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      localparam logic [4:0] IDX = 5'(gi);
      logic set_b, clr_b;
      assign set_b = accept && rd_wr && (dec.rd == IDX);
      assign clr_b = (wb_valid && (wb_rd == IDX)) || (flush_clr && (out_rd_q == IDX));
      assign busy_d[gi] = set_b || (busy_q[gi] && !clr_b);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
      out_rd_q    <= '0;
      out_rd_wr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= in_pc;
        out_instr_q <= in_instr;
        out_op_a_q  <= op_a;
        out_op_b_q  <= op_b;
        out_rd_q    <= dec.rd;
        out_rd_wr_q <= rd_wr;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_op_a  = out_op_a_q;
  assign out_op_b  = out_op_b_q;
  assign out_rd    = out_rd_q;
  assign out_rd_wr = out_rd_wr_q;

endmodule
